// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter and its next-state logic.
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   localparam int COUNTER_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count, terminal-count and wrap-event logic for counter.
// Defining COUNTER_SATURATE_EN makes the count stick at its limits instead of wrapping.
module counter_next
   import counter_pkg::*;
#(
   parameter int          WIDTH   = COUNTER_DEFAULT_WIDTH,
   parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
`ifdef COUNTER_SATURATE_EN
   input  logic             i_sat_hold,
   output logic             o_sat_hold_next,
`endif
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_up_dn,
   output logic [WIDTH-1:0] o_count_next,
   output logic             o_tc,
   output logic             o_wrap_next
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ZERO  = '0;

   dir_e             w_dir;
   logic [WIDTH-1:0] w_load_clip;

   assign w_dir       = dir_e'(i_up_dn);
   assign o_tc        = (w_dir == DIR_UP) ? (i_count == MAX_V) : (i_count == ZERO);
   assign w_load_clip = (i_load_val > MAX_V) ? MAX_V : i_load_val;

   always_comb begin
      o_count_next = i_count;
      o_wrap_next  = 1'b0;
`ifdef COUNTER_SATURATE_EN
      o_sat_hold_next = i_sat_hold;
`endif
      if (i_clr) begin
         o_count_next = ZERO;
`ifdef COUNTER_SATURATE_EN
         o_sat_hold_next = 1'b0;
`endif
      end else if (i_load) begin
         o_count_next = w_load_clip;
`ifdef COUNTER_SATURATE_EN
         o_sat_hold_next = 1'b0;
`endif
      end else if (i_en) begin
         if (o_tc) begin
`ifdef COUNTER_SATURATE_EN
            // Only the first attempt at the limit pulses; the hold flag masks repeats.
            o_wrap_next     = ~i_sat_hold;
            o_sat_hold_next = 1'b1;
`else
            o_count_next = (w_dir == DIR_UP) ? ZERO : MAX_V;
            o_wrap_next  = 1'b1;
`endif
         end else begin
            o_count_next = (w_dir == DIR_UP) ? i_count + 1'b1 : i_count - 1'b1;
`ifdef COUNTER_SATURATE_EN
            o_sat_hold_next = 1'b0;
`endif
         end
      end
   end

endmodule

// File: rtl/counter.sv
// Up/down counter with clear, load and wrap pulse; registers and reset only.
// Defining COUNTER_SATURATE_EN selects saturating instead of wrapping behaviour.
module counter
   import counter_pkg::*;
#(
   parameter int          WIDTH   = COUNTER_DEFAULT_WIDTH,
   parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic [WIDTH-1:0] w_count_next;
   logic             w_wrap_next;
`ifdef COUNTER_SATURATE_EN
   logic             r_sat_hold;
   logic             w_sat_hold_next;
`endif

   counter_next #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
   ) u_next (
`ifdef COUNTER_SATURATE_EN
      .i_sat_hold      (r_sat_hold),
      .o_sat_hold_next (w_sat_hold_next),
`endif
      .i_count      (r_count),
      .i_en         (en),
      .i_clr        (clr),
      .i_load       (load),
      .i_load_val   (load_val),
      .i_up_dn      (up_dn),
      .o_count_next (w_count_next),
      .o_tc         (tc),
      .o_wrap_next  (w_wrap_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_count_next;
         r_wrap  <= w_wrap_next;
      end
   end

`ifdef COUNTER_SATURATE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sat_hold <= 1'b0;
      end else begin
         r_sat_hold <= w_sat_hold_next;
      end
   end
`endif

   assign count = r_count;
   assign wrap  = r_wrap;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed sequences, a vector table, a second
// instance with WIDTH=5/MAX_VAL=12, asynchronous reset and a random phase.
module tb_counter;
   import counter_pkg::*;

   localparam int W    = COUNTER_DEFAULT_WIDTH;
   localparam int MAXA = 15;
`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en, clr, load, up_dn;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         tc, wrap;

   logic         b_en, b_clr, b_load, b_up_dn;
   logic [4:0]   b_load_val;
   logic [4:0]   b_count;
   logic         b_tc, b_wrap;

   int           n_checks = 0;
   int           n_fail   = 0;

   logic [W:0]   exp_q[$];
   logic [5:0]   exp_b_q[$];

   logic [W-1:0] m_count;
   bit           m_hold;

   typedef struct {
      logic         en;
      logic         clr;
      logic         load;
      logic [W-1:0] lv;
      logic         up;
      logic [W-1:0] e_cnt;
      logic         e_wrap;
      string        name;
   } vec_t;

   vec_t vecs[17];

   always #5 clk = ~clk;

   counter dut_a (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .up_dn    (up_dn),
      .count    (count),
      .tc       (tc),
      .wrap     (wrap)
   );

   counter #(
      .WIDTH   (5),
      .MAX_VAL (12)
   ) dut_b (
      .clk      (clk),
      .rst      (rst),
      .en       (b_en),
      .clr      (b_clr),
      .load     (b_load),
      .load_val (b_load_val),
      .up_dn    (b_up_dn),
      .count    (b_count),
      .tc       (b_tc),
      .wrap     (b_wrap)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step_a(input string name, input logic a_en, input logic a_clr,
                         input logic a_load, input logic [W-1:0] a_lv, input logic a_up,
                         input logic [W-1:0] e_cnt, input logic e_wrap);
      logic [W:0] e;
      @(negedge clk);
      en = a_en; clr = a_clr; load = a_load; load_val = a_lv; up_dn = a_up;
      exp_q.push_back({e_wrap, e_cnt});
      #1;
      check({name, "_tc"}, 32'(tc), 32'(a_up ? (m_count == W'(MAXA)) : (m_count == '0)));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({name, "_count"}, 32'(count), 32'(e[W-1:0]));
      check({name, "_wrap"}, 32'(wrap), 32'(e[W]));
      m_count = e_cnt;
   endtask

   task automatic step_b(input string name, input logic a_en, input logic a_clr,
                         input logic a_load, input logic [4:0] a_lv, input logic a_up,
                         input logic [4:0] e_cnt, input logic e_wrap);
      logic [5:0] e;
      @(negedge clk);
      b_en = a_en; b_clr = a_clr; b_load = a_load; b_load_val = a_lv; b_up_dn = a_up;
      exp_b_q.push_back({e_wrap, e_cnt});
      @(posedge clk);
      #1;
      e = exp_b_q.pop_front();
      check({name, "_count"}, 32'(b_count), 32'(e[4:0]));
      check({name, "_wrap"}, 32'(b_wrap), 32'(e[5]));
   endtask

   // Reference behaviour for the WIDTH=4 instance, used only by the random phase.
   task automatic model_step(input logic a_en, input logic a_clr, input logic a_load,
                             input logic [W-1:0] a_lv, input logic a_up,
                             output logic [W-1:0] n, output logic w);
      n = m_count;
      w = 1'b0;
      if (a_clr) begin
         n = '0;
         m_hold = 1'b0;
      end else if (a_load) begin
         n = a_lv;
         m_hold = 1'b0;
      end else if (a_en) begin
         if ((a_up && m_count == W'(MAXA)) || (!a_up && m_count == '0)) begin
            if (SAT) begin
               w = !m_hold;
               m_hold = 1'b1;
            end else begin
               n = a_up ? '0 : W'(MAXA);
               w = 1'b1;
            end
         end else begin
            n = a_up ? m_count + 4'd1 : m_count - 4'd1;
            m_hold = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] n_cnt;
      logic         n_wrap;
      logic         r_en, r_clr, r_load, r_up;
      logic [W-1:0] r_lv;
      int           r;

      vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'd7,  1'b1, 4'd0,  1'b0, "prio_clr"};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'd7,  1'b1, 4'd7,  1'b0, "load7"};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd9,  1'b0, 4'd9,  1'b0, "load_over_en"};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9,  1'b0, "hold"};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8,  1'b0, "down"};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd1,  1'b0, 4'd1,  1'b0, "load1"};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, "down_to0"};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, (SAT ? 4'd0 : 4'd15), 1'b1, "down_limit"};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, (SAT ? 4'd0 : 4'd14), 1'b0, "down_after"};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 4'd0,  1'b0, "load0"};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd1,  1'b0, "toggle_up"};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, "toggle_dn"};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd1,  1'b0, "toggle_up2"};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, "clr_en"};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 4'd15, 1'b0, "load15"};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 4'd15, 1'b0, "load_at_tc"};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, "clr_at_tc"};

      en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; up_dn = 1'b1;
      b_en = 1'b0; b_clr = 1'b0; b_load = 1'b0; b_load_val = '0; b_up_dn = 1'b1;
      m_count = '0;
      m_hold  = 1'b0;

      // Reset asserted between edges must clear the outputs without a clock.
      #2 rst = 1'b0;
      #1;
      check("reset_count_async", 32'(count), 32'd0);
      check("reset_wrap_async", 32'(wrap), 32'd0);
      check("reset_b_count_async", 32'(b_count), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("reset_count_held", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 1; i <= 10; i++) step_a("count_up", 1'b1, 1'b0, 1'b0, '0, 1'b1, W'(i), 1'b0);
      repeat (2) step_a("hold_en0", 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd10, 1'b0);
      for (int i = 11; i <= 15; i++) step_a("resume", 1'b1, 1'b0, 1'b0, '0, 1'b1, W'(i), 1'b0);
      step_a("up_limit", 1'b1, 1'b0, 1'b0, '0, 1'b1, (SAT ? 4'd15 : 4'd0), 1'b1);
      step_a("after_limit1", 1'b1, 1'b0, 1'b0, '0, 1'b1, (SAT ? 4'd15 : 4'd1), 1'b0);
      step_a("after_limit2", 1'b1, 1'b0, 1'b0, '0, 1'b1, (SAT ? 4'd15 : 4'd2), 1'b0);
      step_a("clr", 1'b0, 1'b1, 1'b0, '0, 1'b1, 4'd0, 1'b0);

      for (int i = 0; i < 17; i++) begin
         step_a(vecs[i].name, vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].lv,
                vecs[i].up, vecs[i].e_cnt, vecs[i].e_wrap);
      end
      m_hold = 1'b0;

      // Narrow instance: load clipping to MAX_VAL=12 and its limit behaviour.
      step_b("b_prio", 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
      step_b("b_load7", 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
      step_b("b_load20", 1'b0, 1'b0, 1'b1, 5'd20, 1'b1, 5'd12, 1'b0);
      check("b_tc_at_max", 32'(b_tc), 32'd1);
      step_b("b_limit", 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, (SAT ? 5'd12 : 5'd0), 1'b1);
      step_b("b_load31", 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 5'd12, 1'b0);
      check("b_tc_dn_at_max", 32'(b_tc), 32'd0);
      step_b("b_down", 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b0);
      b_en = 1'b0; b_load = 1'b0;

      // Mid-count asynchronous reset.
      step_a("load9", 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 4'd9, 1'b0);
      @(negedge clk);
      en = 1'b1; load = 1'b0; up_dn = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("midreset_count", 32'(count), 32'd0);
      check("midreset_wrap", 32'(wrap), 32'd0);
      check("midreset_b_count", 32'(b_count), 32'd0);
      @(posedge clk);
      #1;
      check("midreset_count_edge", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      m_count = '0;
      m_hold  = 1'b0;
      step_a("first_after_reset", 1'b1, 1'b0, 1'b0, '0, 1'b1, 4'd1, 1'b0);

      for (int i = 0; i < 80; i++) begin
         r      = $urandom_range(0, 15);
         r_clr  = (r == 0);
         r_load = (r == 1);
         r_en   = ($urandom_range(0, 3) != 0);
         r_up   = ($urandom_range(0, 2) != 0);
         r_lv   = W'($urandom_range(0, MAXA));
         model_step(r_en, r_clr, r_load, r_lv, r_up, n_cnt, n_wrap);
         step_a("rand", r_en, r_clr, r_load, r_lv, r_up, n_cnt, n_wrap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
